obstacle_manager: RTL and testbench
===================================

Name: obstacle_manager

Overview:
- Parametrised successor to the fixed two-obstacle scroller: manages NUM_OBS independent obstacle slots.
- Includes spawn scheduling with a randomised minimum gap, and a per-game speed ramp.
- Runs on the system clock, with game_tick used as an enable rather than as a clock.
- Feeds obs_render instances (position/type) and receives game_start_pulse, game_frozen and rng from the top level.

Parameters:
- NUM_OBS, 3: number of obstacle slots (2..4).
- CONV, 2: pixel-to-game-coordinate shift; position width POS_W = 10-CONV.
- SCREEN_W, 160: visible width in game units (640>>CONV); also the off-screen parked position.
- MIN_GAP, 40: minimum game units scrolled between consecutive spawns.
- SPEED_MAX, 4: maximum scroll step per tick (game units).
- SPEED_STEP_TICKS, 600: game_ticks between speed increments.
- TYPE_W, 3: obstacle type width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- game_tick  in  1  one-cycle pulse per frame (60 Hz)
- game_start  in  1  one-cycle pulse: begin new game
- game_frozen  in  1  level: game over/idle, motion halted
- rng  in  8  free-running LFSR value
- obs_pos  out  NUM_OBS*POS_W  slot i position at [i*POS_W +: POS_W]
- obs_type  out  NUM_OBS*TYPE_W  slot i type
- obs_active  out  NUM_OBS  slot i visible/occupied
- speed  out  3  current scroll step
- spawn_pulse  out  1  one-cycle pulse when a slot is filled

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: obs_pos = SCREEN_W for every slot; obs_type = 0; obs_active = 0; speed = 1; spawn_pulse = 0; gap_cnt = 0; gap_target = MIN_GAP; step_cnt = 0; FSM = FROZEN.
- FSM states: FROZEN, RUN.
  - FROZEN -> RUN on game_start.
  - RUN -> FROZEN when game_frozen = 1 and game_start = 0.
  - FROZEN holds all registers; obstacles stay drawn at their last positions.
- game_start (any state):
  - All slots: active = 0, pos = SCREEN_W.
  - speed = 1; step_cnt = 0; gap_cnt = 0; gap_target = MIN_GAP + rng[5:0].
  - Takes priority over a coincident game_tick; that tick is dropped.
- On game_tick in RUN (all updates land on the following clk edge, i.e. 1-cycle latency):
  - Scroll: each active slot with pos >= speed gets pos -= speed.
  - Retire: each active slot with pos < speed gets active = 0, pos = SCREEN_W. There is no underflow/wrap, ever.
  - Gap: gap_cnt += speed, saturating at 255.
  - Spawn: if gap_cnt >= gap_target and at least one slot is inactive (counting slots retired this same tick as free):
    - Fill the lowest-index free slot: active = 1, pos = SCREEN_W-1, type = rng[TYPE_W-1:0].
    - gap_cnt = 0; gap_target = MIN_GAP + rng[5:0]; spawn_pulse = 1 for one cycle.
  - All slots full: spawn is deferred, not lost. gap_cnt keeps saturating and the spawn fires on the first tick a slot frees.
  - Speed ramp: step_cnt++. At SPEED_STEP_TICKS-1, step_cnt = 0 and speed = min(speed+1, SPEED_MAX).
- game_tick outside RUN: ignored.
- Outputs are registered; spawn_pulse is the only pulse output.

Optional Feature:
- Macro: OBS_SPEED_RAMP_EN.
- Defined: speed ramp as above.
- Undefined: step_cnt is not implemented and speed is constant 1 for the whole game; all other behaviour is unchanged.

Decomposition:
- Package dino_pkg:
  - Constants: CONV, SCREEN_W, POS_W.
  - Obstacle type enum (CACTUS_S, CACTUS_L, BIRD_LO, BIRD_HI, ...).
  - FSM state typedef.
- Sub-module obs_slot, instantiated NUM_OBS times via generate:
  - Holds pos/type/active.
  - Performs scroll/retire given speed and tick.
  - Accepts a load strobe with type.
- The parent keeps the FSM, gap/speed counters and the lowest-free priority encoder.

Test Plan:
- Reset then release: all obs_active = 0, obs_pos = 160 each, speed = 1, no spawn_pulse over 100 ticks while frozen.
- game_start with rng = 0x00, then ticks with game_frozen = 0: first spawn_pulse after 40 ticks, in slot 0 at pos 159; next tick slot 0 pos = 158.
- Slot reaching pos 0 at speed 1: on the next tick it reads active = 0, pos = 160; no wrap to high values. Repeat at speed 3 with pos = 2: retires, not underflows.
- All 3 slots active and gap satisfied: no spawn. When slot 1 retires, that same tick loads slot 1 (lowest free) and spawn_pulse asserts.
- game_start coincident with game_tick mid-game: all slots cleared, speed = 1, positions not decremented that cycle.
- With OBS_SPEED_RAMP_EN defined: speed = 2 after 600 ticks and saturates at 4 after 1800 ticks. Undefined: speed = 1 after 2000 ticks. Asserting rst_n low mid-game restores all reset values asynchronously.

Source files
------------

// File: rtl/dino_pkg.sv
// Purpose : shared constants, obstacle type and manager state encodings for the obstacle scroller.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: CONV, POS_W, SCREEN_W constants; obs_kind_e; mgr_state_e; sat_add8 helper.
package dino_pkg;

  localparam int CONV     = 2;
  localparam int POS_W    = 10 - CONV;
  localparam int SCREEN_W = 640 >> CONV;

  typedef enum logic [2:0] {
    CACTUS_S   = 3'd0,
    CACTUS_L   = 3'd1,
    BIRD_LO    = 3'd2,
    BIRD_HI    = 3'd3,
    CACTUS_GRP = 3'd4
  } obs_kind_e;

  typedef enum logic {
    ST_FROZEN = 1'b0,
    ST_RUN    = 1'b1
  } mgr_state_e;

  // 8-bit add that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/obs_slot.sv
// Purpose : one obstacle slot: holds pos/type/active, scrolls left by speed on tick, retires at the left edge.
// Latency : 1 cycle from tick/load/clear to registered outputs.
// Backpressure: none; tick is an enable, load is only honoured together with tick.
// Ports   : clk, rst_n; clear (new game), tick, speed, load + load_type (spawn strobe);
//           pos, typ, active (registered); free_next (comb: slot is or becomes free on this tick).
module obs_slot #(
  parameter int POS_W    = 8,
  parameter int TYPE_W   = 3,
  parameter int SCREEN_W = 160
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              tick,
  input  logic [2:0]        speed,
  input  logic              load,
  input  logic [TYPE_W-1:0] load_type,
  output logic [POS_W-1:0]  pos,
  output logic [TYPE_W-1:0] typ,
  output logic              active,
  output logic              free_next
);

  logic [POS_W-1:0]  pos_q, pos_d;
  logic [TYPE_W-1:0] type_q, type_d;
  logic              active_q, active_d;
  logic              retire;
  logic [POS_W-1:0]  step;

  always_comb begin
    step      = POS_W'(speed);
    // A slot closer to the edge than one step parks instead of subtracting,
    // so the position can never wrap to a large value.
    retire    = active_q && (pos_q < step);
    free_next = !active_q || retire;

    pos_d    = pos_q;
    type_d   = type_q;
    active_d = active_q;
    if (clear) begin
      active_d = 1'b0;
      pos_d    = POS_W'(SCREEN_W);
    end else if (tick) begin
      if (load) begin
        active_d = 1'b1;
        pos_d    = POS_W'(SCREEN_W - 1);
        type_d   = load_type;
      end else if (retire) begin
        active_d = 1'b0;
        pos_d    = POS_W'(SCREEN_W);
      end else if (active_q) begin
        pos_d = pos_q - step;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q    <= POS_W'(SCREEN_W);
      type_q   <= '0;
      active_q <= 1'b0;
    end else begin
      pos_q    <= pos_d;
      type_q   <= type_d;
      active_q <= active_d;
    end
  end

  assign pos    = pos_q;
  assign typ    = type_q;
  assign active = active_q;

endmodule

// File: rtl/obstacle_manager.sv
// Purpose : NUM_OBS-slot obstacle scroller with randomised spawn gap and optional per-game speed ramp.
// Latency : 1 cycle from game_tick/game_start to updated obstacle outputs and spawn_pulse.
// Backpressure: none; a spawn with every slot full is held (gap_cnt saturates) until a slot frees.
// Ports   : clk, rst_n, game_tick, game_start, game_frozen, rng[7:0] in;
//           obs_pos, obs_type, obs_active (per-slot packed), speed[2:0], spawn_pulse out.
// Config  : define OBS_SPEED_RAMP_EN to enable the speed ramp; otherwise speed stays 1.
module obstacle_manager #(
  parameter int NUM_OBS          = 3,
  parameter int CONV             = dino_pkg::CONV,
  parameter int SCREEN_W         = dino_pkg::SCREEN_W,
  parameter int MIN_GAP          = 40,
  parameter int SPEED_MAX        = 4,
  parameter int SPEED_STEP_TICKS = 600,
  parameter int TYPE_W           = 3,
  localparam int POS_W           = 10 - CONV
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      game_tick,
  input  logic                      game_start,
  input  logic                      game_frozen,
  input  logic [7:0]                rng,
  output logic [NUM_OBS*POS_W-1:0]  obs_pos,
  output logic [NUM_OBS*TYPE_W-1:0] obs_type,
  output logic [NUM_OBS-1:0]        obs_active,
  output logic [2:0]                speed,
  output logic                      spawn_pulse
);

  import dino_pkg::*;

  mgr_state_e         state_q, state_d;
  logic               run_tick;
  logic [2:0]         speed_cur;
  logic [7:0]         gap_cnt_q, gap_cnt_d;
  logic [7:0]         gap_target_q, gap_target_d;
  logic [7:0]         gap_sum;
  logic [7:0]         new_target;
  logic               spawn;
  logic               spawn_pulse_q;
  logic [NUM_OBS-1:0] free_next;
  logic [NUM_OBS-1:0] lowest_free;
  logic [NUM_OBS-1:0] load_vec;
  logic               unused_rng;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_FROZEN;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FROZEN: if (game_start)                 state_d = ST_RUN;
      ST_RUN:    if (game_frozen && !game_start) state_d = ST_FROZEN;
      default:   state_d = ST_FROZEN;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // A tick that coincides with game_start is dropped; the restart wins.
  always_comb begin
    run_tick = (state_q == ST_RUN) && game_tick && !game_start && !game_frozen;
  end

  // ---------------- obstacle slots ----------------
  for (genvar i = 0; i < NUM_OBS; i++) begin : g_slot
    obs_slot #(
      .POS_W    (POS_W),
      .TYPE_W   (TYPE_W),
      .SCREEN_W (SCREEN_W)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (game_start),
      .tick      (run_tick),
      .speed     (speed_cur),
      .load      (load_vec[i]),
      .load_type (rng[TYPE_W-1:0]),
      .pos       (obs_pos[i*POS_W +: POS_W]),
      .typ       (obs_type[i*TYPE_W +: TYPE_W]),
      .active    (obs_active[i]),
      .free_next (free_next[i])
    );
  end

  // Lowest-index free slot; slots retiring on this tick already count as free.
  always_comb begin
    lowest_free = '0;
    for (int i = NUM_OBS - 1; i >= 0; i--) begin
      if (free_next[i]) begin
        lowest_free    = '0;
        lowest_free[i] = 1'b1;
      end
    end
  end

  // ---------------- spawn gap scheduling ----------------
  always_comb begin
    gap_sum    = sat_add8(gap_cnt_q, {5'b0, speed_cur});
    new_target = 8'(MIN_GAP) + {2'b00, rng[5:0]};
    // Compare against the post-increment count so a gap of exactly
    // gap_target units scrolled fires on that tick.
    spawn      = run_tick && (gap_sum >= gap_target_q) && (|free_next);
    load_vec   = spawn ? lowest_free : '0;

    gap_cnt_d    = gap_cnt_q;
    gap_target_d = gap_target_q;
    if (game_start) begin
      gap_cnt_d    = 8'd0;
      gap_target_d = new_target;
    end else if (run_tick) begin
      gap_cnt_d = spawn ? 8'd0 : gap_sum;
      if (spawn) gap_target_d = new_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt_q     <= 8'd0;
      gap_target_q  <= 8'(MIN_GAP);
      spawn_pulse_q <= 1'b0;
    end else begin
      gap_cnt_q     <= gap_cnt_d;
      gap_target_q  <= gap_target_d;
      spawn_pulse_q <= spawn;
    end
  end

  // ---------------- speed ----------------
`ifdef OBS_SPEED_RAMP_EN
  localparam int STEP_W = $clog2(SPEED_STEP_TICKS);

  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic [2:0]        speed_q, speed_d;

  always_comb begin
    step_cnt_d = step_cnt_q;
    speed_d    = speed_q;
    if (game_start) begin
      step_cnt_d = '0;
      speed_d    = 3'd1;
    end else if (run_tick) begin
      if (step_cnt_q == STEP_W'(SPEED_STEP_TICKS - 1)) begin
        step_cnt_d = '0;
        if (speed_q < 3'(SPEED_MAX)) speed_d = speed_q + 3'd1;
      end else begin
        step_cnt_d = step_cnt_q + STEP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt_q <= '0;
      speed_q    <= 3'd1;
    end else begin
      step_cnt_q <= step_cnt_d;
      speed_q    <= speed_d;
    end
  end

  assign speed_cur = speed_q;
`else
  logic [31:0] unused_ramp_cfg;
  assign unused_ramp_cfg = 32'(SPEED_MAX + SPEED_STEP_TICKS);
  assign speed_cur = 3'd1;
`endif

  assign speed       = speed_cur;
  assign spawn_pulse = spawn_pulse_q;
  assign unused_rng  = ^rng[7:6];

endmodule

// File: tb/tb_obstacle_manager.sv
// Purpose : directed self-checking bench for obstacle_manager (default 3 slots, 160-unit screen).
// Latency : n/a.
// Backpressure: n/a.
module tb_obstacle_manager;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        game_tick;
  logic        game_start;
  logic        game_frozen;
  logic [7:0]  rng;
  logic [23:0] obs_pos;
  logic [8:0]  obs_type;
  logic [2:0]  obs_active;
  logic [2:0]  speed;
  logic        spawn_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  obstacle_manager dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .game_tick   (game_tick),
    .game_start  (game_start),
    .game_frozen (game_frozen),
    .rng         (rng),
    .obs_pos     (obs_pos),
    .obs_type    (obs_type),
    .obs_active  (obs_active),
    .speed       (speed),
    .spawn_pulse (spawn_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pos_of(input int i);
    return obs_pos[i*8 +: 8];
  endfunction

  function automatic logic [2:0] type_of(input int i);
    return obs_type[i*3 +: 3];
  endfunction

  // All drives happen on the falling edge; on return we sit on the falling
  // edge right after the rising edge that consumed the stimulus.
  task automatic do_tick();
    game_tick = 1'b1;
    @(negedge clk);
    game_tick = 1'b0;
  endtask

  task automatic do_start();
    game_start = 1'b1;
    @(negedge clk);
    game_start = 1'b0;
  endtask

  task automatic do_start_tick();
    game_start = 1'b1;
    game_tick  = 1'b1;
    @(negedge clk);
    game_start = 1'b0;
    game_tick  = 1'b0;
  endtask

  localparam logic [23:0] ALL_PARKED = {8'd160, 8'd160, 8'd160};

  initial begin
    int spawns;
    int bad;
    logic exp_sp;

    rst_n       = 1'b0;
    game_tick   = 1'b0;
    game_start  = 1'b0;
    game_frozen = 1'b1;
    rng         = 8'h00;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    chk("rst_active", obs_active, 3'b000);
    chk("rst_pos",    obs_pos,    ALL_PARKED);
    chk("rst_type",   obs_type,   9'd0);
    chk("rst_speed",  speed,      3'd1);
    chk("rst_spawn",  spawn_pulse, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // ---- frozen after reset: ticks ignored ----
    spawns = 0;
    for (int k = 0; k < 100; k++) begin
      do_tick();
      if (spawn_pulse) spawns++;
    end
    chk("frozen_spawns", spawns, 0);
    chk("frozen_pos",    obs_pos, ALL_PARKED);
    chk("frozen_active", obs_active, 3'b000);

    // ---- new game: spawn timing, scroll, deferral, lowest-free, retire ----
    game_frozen = 1'b0;
    do_start();
    chk("start_active", obs_active, 3'b000);
    chk("start_pos",    obs_pos, ALL_PARKED);
    for (int t = 1; t <= 300; t++) begin
      rng = (t == 40) ? 8'h05 : (t == 245) ? 8'h3F : 8'h00;
      do_tick();
      exp_sp = (t == 40) || (t == 85) || (t == 125) || (t == 200) || (t == 245);
      chk($sformatf("spawn_t%0d", t), spawn_pulse, exp_sp);
      case (t)
        40: begin
          chk("t40_active", obs_active, 3'b001);
          chk("t40_pos0",   pos_of(0), 8'd159);
          chk("t40_type0",  type_of(0), 3'd5);
        end
        41:  chk("t41_pos0", pos_of(0), 8'd158);
        85: begin
          chk("t85_active", obs_active, 3'b011);
          chk("t85_pos1",   pos_of(1), 8'd159);
          chk("t85_pos0",   pos_of(0), 8'd114);
          chk("t85_type1",  type_of(1), 3'd0);
        end
        125: begin
          chk("t125_active", obs_active, 3'b111);
          chk("t125_pos2",   pos_of(2), 8'd159);
        end
        199: begin
          chk("t199_active", obs_active, 3'b111);
          chk("t199_pos0",   pos_of(0), 8'd0);
        end
        200: begin
          chk("t200_active", obs_active, 3'b111);
          chk("t200_pos0",   pos_of(0), 8'd159);
          chk("t200_pos1",   pos_of(1), 8'd44);
        end
        244: begin
          chk("t244_pos1", pos_of(1), 8'd0);
          chk("t244_pos2", pos_of(2), 8'd40);
        end
        245: begin
          chk("t245_active", obs_active, 3'b111);
          chk("t245_pos1",   pos_of(1), 8'd159);
          chk("t245_type1",  type_of(1), 3'd7);
          chk("t245_pos0",   pos_of(0), 8'd114);
        end
        284: begin
          chk("t284_active", obs_active, 3'b111);
          chk("t284_pos2",   pos_of(2), 8'd0);
        end
        285: begin
          chk("t285_active", obs_active, 3'b011);
          chk("t285_pos2",   pos_of(2), 8'd160);
        end
        300: begin
          chk("t300_pos2",  pos_of(2), 8'd160);
          chk("t300_speed", speed, 3'd1);
        end
        default: ;
      endcase
    end

    // ---- restart coincident with a tick: tick dropped, everything cleared ----
    rng = 8'h00;
    do_start_tick();
    chk("restart_active", obs_active, 3'b000);
    chk("restart_pos",    obs_pos, ALL_PARKED);
    chk("restart_speed",  speed, 3'd1);
    chk("restart_spawn",  spawn_pulse, 1'b0);
    for (int t = 1; t <= 40; t++) begin
      do_tick();
      chk($sformatf("rs_spawn_t%0d", t), spawn_pulse, (t == 40));
    end
    chk("rs_active", obs_active, 3'b001);
    chk("rs_pos0",   pos_of(0), 8'd159);

    // ---- game over: motion halts, obstacles stay drawn ----
    game_frozen = 1'b1;
    repeat (2) @(negedge clk);
    spawns = 0;
    for (int k = 0; k < 10; k++) begin
      do_tick();
      if (spawn_pulse) spawns++;
    end
    chk("over_pos0",   pos_of(0), 8'd159);
    chk("over_active", obs_active, 3'b001);
    chk("over_spawns", spawns, 0);

    // ---- long game: speed profile, no wrap at any speed ----
    game_frozen = 1'b0;
    do_start();
    bad    = 0;
    spawns = 0;
    for (int k = 1; k <= 2000; k++) begin
      rng = 8'(k * 37);
      do_tick();
      if (spawn_pulse) spawns++;
      for (int i = 0; i < 3; i++) begin
        if (obs_active[i] ? (pos_of(i) > 8'd159) : (pos_of(i) != 8'd160)) bad++;
      end
`ifdef OBS_SPEED_RAMP_EN
      case (k)
        599:  chk("ramp_599",  speed, 3'd1);
        600:  chk("ramp_600",  speed, 3'd2);
        1199: chk("ramp_1199", speed, 3'd2);
        1200: chk("ramp_1200", speed, 3'd3);
        1800: chk("ramp_1800", speed, 3'd4);
        2000: chk("ramp_2000", speed, 3'd4);
        default: ;
      endcase
`else
      if (k == 2000) chk("const_speed_2000", speed, 3'd1);
`endif
    end
    chk("long_pos_range", bad, 0);
    chk("long_spawned",   (spawns > 10), 1'b1);
    chk("pre_rst_busy",   (obs_active != 3'b000), 1'b1);

    // ---- asynchronous reset mid-game, away from any clock edge ----
    #2 rst_n = 1'b0;
    #1;
    chk("arst_active", obs_active, 3'b000);
    chk("arst_pos",    obs_pos, ALL_PARKED);
    chk("arst_type",   obs_type, 9'd0);
    chk("arst_speed",  speed, 3'd1);
    chk("arst_spawn",  spawn_pulse, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    spawns = 0;
    for (int k = 0; k < 50; k++) begin
      do_tick();
      if (spawn_pulse) spawns++;
    end
    chk("post_rst_frozen_spawns", spawns, 0);
    chk("post_rst_frozen_pos",    obs_pos, ALL_PARKED);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
